// File: rtl/mna_flit_boxer.sv
//------------------------------------------------------------------------------
// mna_flit_boxer
//   Packs one read/write request into a header, address and (writes only)
//   data flit for NoC injection; counts fully sent packets.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mna_flit_boxer #(
   parameter logic [3:0] SRC_ID = 4'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_dest,
   output logic        noc_valid,
   input  logic        noc_ready,
   output logic [33:0] noc_data,
   output logic [15:0] pkt_count
);

   localparam logic [1:0] FT_HEAD = 2'b10;
   localparam logic [1:0] FT_ADDR = 2'b00;
   localparam logic [1:0] FT_DATA = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HEAD = 2'd1,
      S_ADDR = 2'd2,
      S_DATA = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        write_q;
   logic        noc_valid_q;
   logic [33:0] noc_data_q;
   logic [15:0] pkt_count_q;

   logic [33:0] header_d;
   logic [15:0] pkt_count_d;

   // Header is built straight from the request so it can be presented the
   // cycle after acceptance; dest lives on inside the registered flit.
   assign header_d    = {FT_HEAD, 7'b0, req_dest, SRC_ID, req_write, 16'b0};
   assign pkt_count_d = pkt_count_q + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         write_q     <= 1'b0;
         noc_valid_q <= 1'b0;
         noc_data_q  <= '0;
         pkt_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q      <= req_addr;
                  data_q      <= req_data;
                  write_q     <= req_write;
                  noc_valid_q <= 1'b1;
                  noc_data_q  <= header_d;
                  state_q     <= S_HEAD;
               end
            end
            S_HEAD: begin
               if (noc_ready) begin
                  noc_data_q <= {FT_ADDR, addr_q};
                  state_q    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (noc_ready) begin
                  if (write_q) begin
                     noc_data_q <= {FT_DATA, data_q};
                     state_q    <= S_DATA;
                  end else begin
                     noc_valid_q <= 1'b0;
                     noc_data_q  <= '0;
                     pkt_count_q <= pkt_count_d;
                     state_q     <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (noc_ready) begin
                  noc_valid_q <= 1'b0;
                  noc_data_q  <= '0;
                  pkt_count_q <= pkt_count_d;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               noc_valid_q <= 1'b0;
               noc_data_q  <= '0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   // Decoded from state so it is already high while reset is asserted.
   assign req_ready = (state_q == S_IDLE);
   assign noc_valid = noc_valid_q;
   assign noc_data  = noc_data_q;
   assign pkt_count = pkt_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mna_flit_boxer.sv
//------------------------------------------------------------------------------
// tb_mna_flit_boxer
//   Self-checking bench: queue-based flit model plus directed literal checks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mna_flit_boxer;

   localparam logic [3:0] SRC = 4'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_dest = '0;
   logic        noc_valid;
   logic        noc_ready = 1'b0;
   logic [33:0] noc_data;
   logic [15:0] pkt_count;

   mna_flit_boxer #(.SRC_ID(SRC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_dest  (req_dest),
      .noc_valid (noc_valid),
      .noc_ready (noc_ready),
      .noc_data  (noc_data),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state: pending flits of the packet in flight ({last, flit}),
   // packet counter, flits seen on the wire, and acceptance cycle stamps.
   logic [34:0] exp_q[$];
   logic [33:0] seen[$];
   int          acc_cyc[$];
   logic [15:0] cnt = '0;
   int          cyc = 0;
   logic        hold = 1'b0;
   logic [33:0] hold_data = '0;
   logic        rmode = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      bit idle_now;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         cnt  = '0;
         hold = 1'b0;
      end else begin
         idle_now = (exp_q.size() == 0);
         chk("noc_valid", {63'b0, noc_valid}, {63'b0, !idle_now});
         chk("req_ready", {63'b0, req_ready}, {63'b0, idle_now});
         chk("pkt_count", {48'b0, pkt_count}, {48'b0, cnt});
         if (hold)
            chk("stall_hold", {30'b0, noc_data}, {30'b0, hold_data});
         if (idle_now) begin
            chk("idle_data", {30'b0, noc_data}, 64'b0);
         end else begin
            chk("flit", {30'b0, noc_data}, {30'b0, exp_q[0][33:0]});
            if (noc_valid && noc_ready) begin
               seen.push_back(noc_data);
               if (exp_q[0][34]) cnt = cnt + 16'd1;
               void'(exp_q.pop_front());
            end
         end
         hold      = noc_valid && !noc_ready;
         hold_data = noc_data;
         if (req_valid && idle_now) begin
            exp_q.push_back({1'b0, 2'b10, 7'b0, req_dest, SRC, req_write, 16'b0});
            exp_q.push_back({!req_write, 2'b00, req_addr});
            if (req_write) exp_q.push_back({1'b1, 2'b01, req_data});
            acc_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rmode) noc_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] dst);
      bit acc;
      acc       = 1'b0;
      req_write = w;
      req_addr  = a;
      req_data  = d;
      req_dest  = dst;
      req_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #2;
         if (acc) break;
      end
      if (!acc) begin
         bad++;
         total++;
         $display("FAIL accept_timeout: got no acceptance expected one within 400 cycles");
      end
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_data  = $urandom;
      req_dest  = 4'($urandom);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !noc_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         bad++;
         total++;
         $display("FAIL idle_timeout: got busy expected idle within 400 cycles");
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500us");
      $fatal(1);
   end

   initial begin
      step(3);
      rst_n = 1'b1;
      step(2);

      // Asynchronous reset mid-cycle, then noc_ready alone must not create flits.
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {63'b0, noc_valid}, 64'd0);
      chk("rst_data", {30'b0, noc_data}, 64'd0);
      chk("rst_count", {48'b0, pkt_count}, 64'd0);
      chk("rst_ready", {63'b0, req_ready}, 64'd1);
      step(1);
      rst_n = 1'b1;
      noc_ready = 1'b1;
      seen.delete();
      step(10);
      chk("idle_no_flit", 64'(seen.size()), 64'd0);

      // Read packet.
      seen.delete();
      send(1'b0, 32'h1000_0040, 32'h0, 4'h5);
      wait_idle();
      chk("rd_nflits", 64'(seen.size()), 64'd2);
      chk("rd_head", {30'b0, seen[0]}, 64'h2_00A6_0000);
      chk("rd_addr", {30'b0, seen[1]}, 64'h0_1000_0040);
      chk("rd_count", {48'b0, pkt_count}, 64'd1);

      // Write packet with 3 stalled cycles in front of each flit.
      seen.delete();
      noc_ready = 1'b0;
      send(1'b1, 32'hDEAD_BEEC, 32'h1234_5678, 4'hA);
      for (int f = 0; f < 3; f++) begin
         step(3);
         noc_ready = 1'b1;
         step(1);
         noc_ready = 1'b0;
      end
      wait_idle();
      chk("wr_nflits", 64'(seen.size()), 64'd3);
      chk("wr_head", {30'b0, seen[0]}, 64'h2_0147_0000);
      chk("wr_addr", {30'b0, seen[1]}, 64'h0_DEAD_BEEC);
      chk("wr_data", {30'b0, seen[2]}, 64'h1_1234_5678);
      chk("wr_count", {48'b0, pkt_count}, 64'd2);

      // Back-to-back alternating read/write with req_valid held.
      noc_ready = 1'b1;
      acc_cyc.delete();
      send(1'b0, 32'h0000_1000, 32'h0, 4'h1);
      send(1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 4'h2);
      send(1'b0, 32'h0000_3000, 32'h0, 4'h3);
      send(1'b1, 32'h0000_4000, 32'h5A5A_5A5A, 4'h4);
      wait_idle();
      chk("b2b_naccept", 64'(acc_cyc.size()), 64'd4);
      if (acc_cyc.size() == 4) begin
         chk("b2b_rd_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
         chk("b2b_wr_gap", 64'(acc_cyc[2] - acc_cyc[1]), 64'd4);
         chk("b2b_rd_gap2", 64'(acc_cyc[3] - acc_cyc[2]), 64'd3);
      end
      chk("b2b_count", {48'b0, pkt_count}, 64'd6);

      // Reset while the address flit of a write is stalled.
      noc_ready = 1'b0;
      send(1'b1, 32'hCAFE_0000, 32'h0BAD_F00D, 4'h7);
      noc_ready = 1'b1;
      step(1);
      noc_ready = 1'b0;
      step(2);
      chk("mid_stalled", {63'b0, noc_valid}, 64'd1);
      chk("mid_addr", {30'b0, noc_data}, 64'h0_CAFE_0000);
      rst_n = 1'b0;
      #1;
      chk("mid_valid", {63'b0, noc_valid}, 64'd0);
      chk("mid_count", {48'b0, pkt_count}, 64'd0);
      step(1);
      rst_n = 1'b1;
      noc_ready = 1'b1;
      seen.delete();
      send(1'b0, 32'h0000_0100, 32'h0, 4'h1);
      wait_idle();
      chk("post_rst_head", {30'b0, seen[0]}, 64'h2_0026_0000);
      chk("post_rst_count", {48'b0, pkt_count}, 64'd1);

      // Counter wrap: preload just below the top, then two reads.
      force dut.pkt_count_q = 16'hFFFE;
      cnt = 16'hFFFE;
      #1;
      release dut.pkt_count_q;
      step(1);
      send(1'b0, 32'h0000_0200, 32'h0, 4'h2);
      wait_idle();
      chk("wrap_top", {48'b0, pkt_count}, 64'h0000_FFFF);
      send(1'b0, 32'h0000_0300, 32'h0, 4'h2);
      wait_idle();
      chk("wrap_zero", {48'b0, pkt_count}, 64'h0);

      // Randomized traffic with random backpressure and idle gaps.
      rmode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(0, 2));
         send(1'($urandom), $urandom, $urandom, 4'($urandom));
      end
      rmode = 1'b0;
      noc_ready = 1'b1;
      wait_idle();
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
